// File: rtl/game_tick_scheduler_pkg.sv
// rtl/game_tick_scheduler_pkg.sv - shared state encoding and default divider constants
package game_pkg;

    localparam int CNT_W = 32;

    localparam int DOODLE_DIV_DEF    = 250000;
    localparam int GRAVITY_DIV_DEF   = 500000;
    localparam int POINTS_DIV_DEF    = 5000000;
    localparam int PLAT_DIV_INIT_DEF = 500000;
    localparam int PLAT_DIV_MIN_DEF  = 200000;
    localparam int PLAT_DIV_STEP_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/game_tick_scheduler_if.sv
// rtl/game_tick_scheduler_if.sv - game control inputs and tick/state outputs of the scheduler
interface game_tick_scheduler_if
    import game_pkg::*;
#(
    parameter int W = CNT_W
);
    logic         start;
    logic         pause;
    logic         game_over;
    logic         doodle_tick;
    logic         gravity_tick;
    logic         platform_tick;
    logic         points_tick;
    logic [1:0]   state;
    logic [W-1:0] plat_div;

    modport master (
        output start, pause, game_over,
        input  doodle_tick, gravity_tick, platform_tick, points_tick, state, plat_div
    );

    modport slave (
        input  start, pause, game_over,
        output doodle_tick, gravity_tick, platform_tick, points_tick, state, plat_div
    );
endinterface

// File: rtl/game_tick_scheduler_tick_gen.sv
// rtl/game_tick_scheduler_tick_gen.sv - enabled period counter producing a registered one-cycle strobe
module tick_gen #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);
    logic [W-1:0] r_count;
    logic         w_wrap;

    // >= so a period that shrinks below the running count wraps at once
    assign w_wrap = (r_count >= (i_period - W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_en) begin
                if (w_wrap) begin
                    r_count <= '0;
                    o_tick  <= 1'b1;
                end else begin
                    r_count <= r_count + W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - game state FSM gating four tick strobes; PLAT_RAMP_EN enables the platform speed ramp
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int DOODLE_DIV    = DOODLE_DIV_DEF,
    parameter int GRAVITY_DIV   = GRAVITY_DIV_DEF,
    parameter int POINTS_DIV    = POINTS_DIV_DEF,
    parameter int PLAT_DIV_INIT = PLAT_DIV_INIT_DEF,
    parameter int PLAT_DIV_MIN  = PLAT_DIV_MIN_DEF,
    parameter int PLAT_DIV_STEP = PLAT_DIV_STEP_DEF,
    parameter int CNT_W         = game_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    game_tick_scheduler_if.slave  bus
);
    state_t             r_state;
    state_t             w_next;
    logic               w_run;
    logic               w_clear;
    logic               w_doodle_tick;
    logic               w_gravity_tick;
    logic               w_platform_tick;
    logic               w_points_tick;
    logic [CNT_W-1:0]   w_plat_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_RUN;
            ST_RUN:   if (bus.game_over) w_next = ST_OVER;
                      else if (bus.pause) w_next = ST_PAUSE;
            ST_PAUSE: if (bus.game_over) w_next = ST_OVER;
                      else if (bus.pause) w_next = ST_RUN;
            ST_OVER:  if (bus.start) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Counting stops on the edge that leaves RUN, so no strobe escapes or is lost across a pause
    assign w_run   = (r_state == ST_RUN) && (w_next == ST_RUN);
    assign w_clear = (r_state == ST_IDLE) && (w_next == ST_RUN);

    tick_gen #(.W(CNT_W)) u_doodle (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(w_clear), .i_en(w_run),
        .i_period(CNT_W'(DOODLE_DIV)), .o_tick(w_doodle_tick)
    );

    tick_gen #(.W(CNT_W)) u_gravity (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(w_clear), .i_en(w_run),
        .i_period(CNT_W'(GRAVITY_DIV)), .o_tick(w_gravity_tick)
    );

    tick_gen #(.W(CNT_W)) u_points (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(w_clear), .i_en(w_run),
        .i_period(CNT_W'(POINTS_DIV)), .o_tick(w_points_tick)
    );

    tick_gen #(.W(CNT_W)) u_platform (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(w_clear), .i_en(w_run),
        .i_period(w_plat_div), .o_tick(w_platform_tick)
    );

`ifdef PLAT_RAMP_EN
    localparam logic [CNT_W-1:0] LP_INIT  = CNT_W'(PLAT_DIV_INIT);
    localparam logic [CNT_W-1:0] LP_MIN   = CNT_W'(PLAT_DIV_MIN);
    localparam logic [CNT_W-1:0] LP_STEP  = CNT_W'(PLAT_DIV_STEP);
    localparam logic [CNT_W-1:0] LP_FLOOR = CNT_W'(PLAT_DIV_MIN + PLAT_DIV_STEP);

    logic [CNT_W-1:0] r_plat_div;

    // Compare against floor+step first so the subtraction can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plat_div <= LP_INIT;
        end else if (w_clear) begin
            r_plat_div <= LP_INIT;
        end else if (w_points_tick) begin
            if (r_plat_div >= LP_FLOOR) r_plat_div <= r_plat_div - LP_STEP;
            else                        r_plat_div <= LP_MIN;
        end
    end

    assign w_plat_div = r_plat_div;
`else
    assign w_plat_div = CNT_W'(PLAT_DIV_INIT);
`endif

    assign bus.state         = r_state;
    assign bus.doodle_tick   = w_doodle_tick;
    assign bus.gravity_tick  = w_gravity_tick;
    assign bus.platform_tick = w_platform_tick;
    assign bus.points_tick   = w_points_tick;
    assign bus.plat_div      = w_plat_div;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - self-checking bench with directed scenarios and random control traffic
module tb_game_tick_scheduler;
    import game_pkg::*;

    localparam int DD = 4;
    localparam int GD = 6;
    localparam int PD = 10;
    localparam int PI = 8;
    localparam int PM = 5;
    localparam int PS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    game_tick_scheduler_if bus ();

    game_tick_scheduler #(
        .DOODLE_DIV(DD), .GRAVITY_DIV(GD), .POINTS_DIV(PD),
        .PLAT_DIV_INIT(PI), .PLAT_DIV_MIN(PM), .PLAT_DIV_STEP(PS), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed RUN cycles per channel, platform phase, state by rule
    int m_state, m_nd, m_ng, m_np, m_phase, m_div;
    bit m_td, m_tg, m_tp, m_tpts;

    always @(posedge clk or negedge rst_n) begin
        int nxt;
        bit run;
        bit old_pts;
        if (!rst_n) begin
            m_state = 0; m_nd = 0; m_ng = 0; m_np = 0; m_phase = 0; m_div = PI;
            m_td = 0; m_tg = 0; m_tp = 0; m_tpts = 0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (bus.start) nxt = 1;
                1: if (bus.game_over) nxt = 3; else if (bus.pause) nxt = 2;
                2: if (bus.game_over) nxt = 3; else if (bus.pause) nxt = 1;
                default: if (bus.start) nxt = 0;
            endcase
            run     = (m_state == 1) && (nxt == 1);
            old_pts = m_tpts;
            m_td = 0; m_tg = 0; m_tp = 0; m_tpts = 0;
            if (m_state == 0 && nxt == 1) begin
                m_nd = 0; m_ng = 0; m_np = 0; m_phase = 0; m_div = PI;
            end
            if (run) begin
                m_nd++; m_ng++; m_np++;
                m_td   = (m_nd % DD) == 0;
                m_tg   = (m_ng % GD) == 0;
                m_tpts = (m_np % PD) == 0;
                if (m_phase >= m_div - 1) begin
                    m_phase = 0;
                    m_tp    = 1;
                end else begin
                    m_phase++;
                end
            end
`ifdef PLAT_RAMP_EN
            if (old_pts) m_div = (m_div - PS < PM) ? PM : m_div - PS;
`endif
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_state",    bus.state,         m_state);
            chk("model_doodle",   bus.doodle_tick,   m_td);
            chk("model_gravity",  bus.gravity_tick,  m_tg);
            chk("model_platform", bus.platform_tick, m_tp);
            chk("model_points",   bus.points_tick,   m_tpts);
            chk("model_plat_div", bus.plat_div,      m_div);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1; step(); bus.pause = 1'b0;
    endtask

    task automatic pulse_over();
        bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
    endtask

    task automatic chk_no_ticks(input string name);
        chk(name, {bus.doodle_tick, bus.gravity_tick, bus.platform_tick, bus.points_tick}, 0);
    endtask

    initial begin
        int plat_cnt;
        bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", bus.state, 0);
        chk("reset_plat_div", bus.plat_div, PI);
        chk_no_ticks("reset_ticks");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Cadence and ramp after start
        pulse_start();
        chk("start_state", bus.state, 1);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("s1_doodle",  bus.doodle_tick,  (k % 4) == 0);
            chk("s1_gravity", bus.gravity_tick, (k % 6) == 0);
            chk("s1_points",  bus.points_tick,  k == 10);
`ifdef PLAT_RAMP_EN
            chk("s1_platform", bus.platform_tick, (k == 8) || (k == 14));
            chk("s1_plat_div", bus.plat_div, (k >= 11) ? 6 : 8);
`else
            chk("s1_platform", bus.platform_tick, k == 8);
            chk("s1_plat_div", bus.plat_div, 8);
`endif
        end
        repeat (26) step();
`ifdef PLAT_RAMP_EN
        chk("s2_plat_div_clamped", bus.plat_div, 5);
`else
        chk("s2_plat_div_const", bus.plat_div, 8);
`endif

        // pause and game_over together: game_over wins
        bus.pause = 1'b1; bus.game_over = 1'b1;
        step();
        bus.pause = 1'b0; bus.game_over = 1'b0;
        chk("s4_over_state", bus.state, 3);
        chk_no_ticks("s4_over_ticks");
        pulse_start();
        chk("s4_idle_state", bus.state, 0);
        pulse_start();
        chk("s4_run_state", bus.state, 1);
        chk("s4_plat_div_reload", bus.plat_div, 8);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s4_doodle_cleared", bus.doodle_tick, k == 4);
        end

        // Pause two cycles into a doodle period
        repeat (2) step();
        pulse_pause();
        chk("s3_pause_state", bus.state, 2);
        for (int k = 0; k < 20; k++) begin
            step();
            chk_no_ticks("s3_paused_ticks");
        end
        pulse_pause();
        chk("s3_resume_state", bus.state, 1);
        step();
        chk("s3_doodle_r1", bus.doodle_tick, 0);
        step();
        chk("s3_doodle_r2", bus.doodle_tick, 1);

        // Fresh game, platform strobe count over 48 RUN cycles
        pulse_over();
        pulse_start();
        pulse_start();
        plat_cnt = 0;
        for (int k = 1; k <= 48; k++) begin
            step();
            if (bus.platform_tick) plat_cnt++;
        end
`ifdef PLAT_RAMP_EN
        chk("s6_platform_count", plat_cnt, 8);
`else
        chk("s6_platform_count", plat_cnt, 6);
        chk("s6_plat_div", bus.plat_div, 8);
`endif

        // Asynchronous reset in mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s5_async_state", bus.state, 0);
        chk("s5_async_plat_div", bus.plat_div, 8);
        chk_no_ticks("s5_async_ticks");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random control traffic against the model
        for (int k = 0; k < 2000; k++) begin
            bus.start     = ($urandom_range(0, 15) == 0);
            bus.pause     = ($urandom_range(0, 40) == 0);
            bus.game_over = ($urandom_range(0, 120) == 0);
            step();
        end
        bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Single-clock scheduler for the Doodle Fall game loop.
- Replaces the divided-clock scheme with one-cycle enable strobes on the 50 MHz master clock.
- Sequences the game state (idle / running / paused / over) and gates the strobes by that state.
- Owns the platform-speed ramp that raises the platform rate as the game progresses.

Parameters:
- DOODLE_DIV, 250000, clk cycles between doodle_tick strobes
- GRAVITY_DIV, 500000, clk cycles between gravity_tick strobes
- POINTS_DIV, 5000000, clk cycles between points_tick strobes
- PLAT_DIV_INIT, 500000, initial platform period in clk cycles
- PLAT_DIV_MIN, 200000, floor for the platform period
- PLAT_DIV_STEP, 1000, platform period decrement per points_tick
- CNT_W, 32, width of all counters and of plat_div

Ports:
- clk  in  1  master clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request: IDLE->RUN or OVER->IDLE
- pause  in  1  one-cycle toggle: RUN<->PAUSE
- game_over  in  1  one-cycle collision/fall event from game logic
- doodle_tick  out  1  one-cycle doodle movement strobe
- gravity_tick  out  1  one-cycle gravity update strobe
- platform_tick  out  1  one-cycle platform scroll strobe
- points_tick  out  1  one-cycle score increment strobe
- state  out  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
- plat_div  out  CNT_W  current platform period

Behaviour:
- Reset (async, rst_n=0) gives the following values:
  - state = IDLE
  - all counters = 0
  - all ticks = 0
  - plat_div = PLAT_DIV_INIT
- All outputs are registered.
- FSM transitions:
  - IDLE: start -> RUN.
  - RUN: game_over -> OVER; else pause -> PAUSE.
  - PAUSE: game_over -> OVER; else pause -> RUN.
  - OVER: start -> IDLE.
- Input priority when inputs coincide: game_over > pause > start. start is ignored in RUN and PAUSE. pause is ignored in IDLE and OVER.
- On the IDLE->RUN transition, all counters clear to 0 and plat_div reloads PLAT_DIV_INIT.
- Counters advance only while state==RUN and freeze in PAUSE. No strobe is lost or duplicated across a pause.
- Fixed channels (doodle, gravity, points):
  - When count == DIV-1: the count wraps to 0 and the tick is 1 on the next cycle.
  - Otherwise the count increments.
  - First tick comes DIV cycles after entering RUN.
- Platform channel:
  - When count >= plat_div-1: the count wraps and platform_tick fires.
  - The >= comparison handles plat_div shrinking below the current count.
- Ramp:
  - On the cycle points_tick is generated, plat_div <= max(plat_div - PLAT_DIV_STEP, PLAT_DIV_MIN).
  - The subtraction is evaluated without underflow: compare before subtracting.
- Ticks may coincide; each is independent.
- Ticks are forced to 0 in every state except RUN, including the cycle of leaving RUN.
- game_over in PAUSE goes to OVER with counters frozen. They are cleared on the next IDLE->RUN.
- In OVER, plat_div holds its value, so the final speed is readable.

Optional Feature:
- Macro PLAT_RAMP_EN.
- Defined: the ramp operates as above.
- Undefined: plat_div is constant PLAT_DIV_INIT and the ramp logic is not synthesized.

Decomposition:
- Package game_pkg holds:
  - state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER)
  - default DIV constants
  - CNT_W
- Sub-module tick_gen has a runtime period input, an enable input and a one-cycle strobe output. It is instantiated four times; the fixed periods are tied to constants.

Test Plan (simulation uses DOODLE_DIV=4, GRAVITY_DIV=6, POINTS_DIV=10, PLAT_DIV_INIT=8, PLAT_DIV_MIN=5, PLAT_DIV_STEP=2):
1. Reset then start -> state=1; doodle_tick every 4 cycles, gravity_tick every 6, first platform_tick 8 cycles after start.
2. Ramp over three points_ticks -> plat_div steps 8 -> 6 -> 5 -> 5 (clamped). Platform spacing follows the new value on the following period.
3. pause after 2 RUN cycles, hold 20 cycles, pause again -> no ticks during PAUSE; next doodle_tick arrives 2 cycles after resume.
4. pause and game_over on the same cycle in RUN -> state=3, all ticks 0; start -> state=0; start -> state=1 with plat_div=8 and counters cleared.
5. rst_n low mid-RUN, asynchronous to clk -> state=0, ticks=0, plat_div=8 immediately, without waiting for a clk edge.
6. PLAT_RAMP_EN undefined, 50 RUN cycles -> plat_div stays 8; platform_tick every 8 cycles.
